// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: clear-engine states
// and default geometry.
package rf_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clear_state_e;

endpackage

// File: rtl/rf_clear_fsm.sv
// Sequential clear engine: walks a pointer over every entry, one per clock,
// then holds DONE for a single cycle before returning to IDLE.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clearReq,
    output logic                  clearBusy,
    output logic                  clearDone,
    output logic                  sweepEn,
    output logic [ADDR_WIDTH-1:0] sweepAddr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    clear_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clearReq) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clearBusy = (state_q != IDLE);
        clearDone = (state_q == DONE);
        sweepEn   = (state_q == SWEEP);
        sweepAddr = ptr_q;
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with optional write bypass, optional
// hard-wired zero entry and a sweep-clear engine.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             changeEnable,
    input  logic                             regWrite,
    input  logic [ADDR_WIDTH-1:0]            writeRegister,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] readAddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    input  logic                             clearReq,
    output logic                             clearBusy,
    output logic                             clearDone
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    logic                  clear_busy;
    logic                  sweep_en;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  write_qual;
    logic                  zero_target;

    rf_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clock     (clock),
        .reset     (reset),
        .clearReq  (clearReq),
        .clearBusy (clear_busy),
        .clearDone (clearDone),
        .sweepEn   (sweep_en),
        .sweepAddr (sweep_addr)
    );

    assign clearBusy = clear_busy;

    // Reset gates the write qualifier so bypassed reads also show 0 while
    // the file is held in reset.
    assign zero_target = (ZERO_REG != 0) && (writeRegister == '0);
    assign write_qual  = reset & regWrite & changeEnable & ~clear_busy & ~zero_target;

    always_comb begin
        regs_d = regs_q;
        if (sweep_en) begin
            regs_d[sweep_addr] = '0;
        end else if (write_qual) begin
            regs_d[writeRegister] = writeData;
        end
    end

    // NOTE: the storage is reset explicitly because the whole file must read
    // 0 from the moment reset is asserted; it cannot map to a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic                  rd_zero;
        logic                  rd_bypass;
        logic [DATA_WIDTH-1:0] rd_val;

        assign rd_addr   = readAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_zero   = (ZERO_REG != 0) && (rd_addr == '0);
        assign rd_bypass = (BYPASS != 0) && write_qual && (writeRegister == rd_addr);
        assign rd_val    = rd_zero   ? '0 :
                           rd_bypass ? writeData :
                                       regs_q[rd_addr];

        assign readData[k*DATA_WIDTH +: DATA_WIDTH] = rd_val;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: two configurations share one
// stimulus stream and are checked against an array-based reference model.
module tb_register_file_mp;

    localparam int NC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        changeEnable;
    logic        regWrite;
    logic [3:0]  writeRegister;
    logic [31:0] writeData;
    logic [3:0]  ra [3];
    logic        clearReq;

    logic [5:0]  ra0;
    logic [11:0] ra1;
    logic [31:0] rd0;
    logic [95:0] rd1;
    logic        busy0, done0, busy1, done1;

    always #5 clock = ~clock;

    assign ra0 = {ra[1][2:0], ra[0][2:0]};
    assign ra1 = {ra[2], ra[1], ra[0]};

    register_file_mp #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3),
        .READ_PORTS (2),
        .BYPASS     (1),
        .ZERO_REG   (0)
    ) dut0 (
        .clock         (clock),
        .reset         (reset),
        .changeEnable  (changeEnable),
        .regWrite      (regWrite),
        .writeRegister (writeRegister[2:0]),
        .writeData     (writeData[15:0]),
        .readAddr      (ra0),
        .readData      (rd0),
        .clearReq      (clearReq),
        .clearBusy     (busy0),
        .clearDone     (done0)
    );

    register_file_mp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .READ_PORTS (3),
        .BYPASS     (0),
        .ZERO_REG   (1)
    ) dut1 (
        .clock         (clock),
        .reset         (reset),
        .changeEnable  (changeEnable),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readAddr      (ra1),
        .readData      (rd1),
        .clearReq      (clearReq),
        .clearBusy     (busy1),
        .clearDone     (done1)
    );

    // Reference model: plain arrays plus a "cycles of clear remaining" count.
    int          depth_c  [NC] = '{8, 16};
    logic [31:0] dmask_c  [NC] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [3:0]  amask_c  [NC] = '{4'h7, 4'hF};
    int          bypass_c [NC] = '{1, 0};
    int          zero_c   [NC] = '{0, 1};
    int          ports_c  [NC] = '{2, 3};

    logic [31:0] mem  [NC][16];
    int          left [NC];

    typedef struct {
        string                   tag;
        logic [NC-1:0][2:0][31:0] rd;
        logic [NC-1:0]           busy;
        logic [NC-1:0]           done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            left[c] = 0;
            for (int a = 0; a < 16; a++) mem[c][a] = 32'h0;
        end
    endfunction

    function automatic logic write_ok(input int c);
        logic [3:0] wa;
        wa = writeRegister & amask_c[c];
        return reset && regWrite && changeEnable && (left[c] == 0)
               && !((zero_c[c] != 0) && (wa == 4'h0));
    endfunction

    function automatic logic [31:0] model_read(input int c, input logic [3:0] a_in);
        logic [3:0] a;
        a = a_in & amask_c[c];
        if (!reset) return 32'h0;
        if ((zero_c[c] != 0) && (a == 4'h0)) return 32'h0;
        if ((bypass_c[c] != 0) && write_ok(c) && ((writeRegister & amask_c[c]) == a))
            return writeData & dmask_c[c];
        return mem[c][a];
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NC; c++) begin
            if (!reset) begin
                left[c] = 0;
                for (int a = 0; a < 16; a++) mem[c][a] = 32'h0;
            end else if (left[c] == 0) begin
                if (write_ok(c)) mem[c][writeRegister & amask_c[c]] = writeData & dmask_c[c];
                if (clearReq) left[c] = depth_c[c] + 1;
            end else begin
                if (left[c] > 1) mem[c][depth_c[c] + 1 - left[c]] = 32'h0;
                left[c]--;
            end
        end
    endfunction

    // One clock of stimulus: predict outputs for the applied inputs, queue
    // them, then advance the model across the edge.
    task automatic cycle(input string tag);
        exp_t e;
        e.tag = tag;
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 3; k++)
                e.rd[c][k] = (k < ports_c[c]) ? model_read(c, ra[k]) : 32'h0;
            e.busy[c] = (left[c] > 0);
            e.done[c] = (left[c] == 1);
        end
        sb.push_back(e);
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic rand_inputs();
        regWrite      = 1'($urandom_range(0, 1));
        changeEnable  = ($urandom_range(0, 3) != 0);
        writeRegister = 4'($urandom_range(0, 15));
        writeData     = $urandom;
        for (int k = 0; k < 3; k++) ra[k] = 4'($urandom_range(0, 15));
        clearReq      = ($urandom_range(0, 31) == 0);
    endtask

    task automatic set_idle();
        regWrite     = 1'b0;
        changeEnable = 1'b1;
        clearReq     = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input string tag);
        regWrite      = 1'b1;
        changeEnable  = 1'b1;
        writeRegister = a;
        writeData     = d;
        cycle(tag);
        regWrite      = 1'b0;
    endtask

    // Monitor: pops one prediction per cycle and compares at the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 2; k++)
                check($sformatf("%s d0.rd%0d", e.tag, k), {16'h0, rd0[k*16 +: 16]}, e.rd[0][k]);
            for (int k = 0; k < 3; k++)
                check($sformatf("%s d1.rd%0d", e.tag, k), rd1[k*32 +: 32], e.rd[1][k]);
            check($sformatf("%s d0.busy", e.tag), {31'h0, busy0}, {31'h0, e.busy[0]});
            check($sformatf("%s d0.done", e.tag), {31'h0, done0}, {31'h0, e.done[0]});
            check($sformatf("%s d1.busy", e.tag), {31'h0, busy1}, {31'h0, e.busy[1]});
            check($sformatf("%s d1.done", e.tag), {31'h0, done1}, {31'h0, e.done[1]});
        end
    end

    initial begin
        model_reset();
        reset = 1'b1;
        set_idle();
        writeRegister = '0;
        writeData     = '0;
        for (int k = 0; k < 3; k++) ra[k] = '0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset held with random traffic on every input.
        for (int i = 0; i < 6; i++) begin
            rand_inputs();
            cycle("in_reset");
        end

        reset = 1'b1;
        set_idle();
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 3; k++) ra[k] = 4'(a);
            cycle("post_reset");
        end

        // Basic write / read and the changeEnable qualifier.
        ra[0] = 4'd3; ra[1] = 4'd0; ra[2] = 4'd3;
        write_reg(4'd3, 32'h0000_A5A5, "wr_r3");
        cycle("rd_r3");
        changeEnable  = 1'b0;
        regWrite      = 1'b1;
        writeRegister = 4'd3;
        writeData     = 32'h0000_BEEF;
        cycle("wr_ce0");
        set_idle();
        cycle("rd_ce0");

        // Bypass: all ports read the register being written.
        for (int k = 0; k < 3; k++) ra[k] = 4'd5;
        write_reg(4'd5, 32'h0000_1234, "bypass");
        cycle("after_bypass");

        // Zero register.
        for (int k = 0; k < 3; k++) ra[k] = 4'd0;
        write_reg(4'd0, 32'hFFFF_FFFF, "zero_wr");
        cycle("zero_rd");

        // Fill, then sweep with a write attempt in the middle.
        for (int i = 0; i < 16; i++) write_reg(4'(i), 32'h0011 * i, "fill");
        clearReq = 1'b1;
        ra[0] = 4'd0; ra[1] = 4'd0; ra[2] = 4'd1;
        cycle("clr_req");
        clearReq = 1'b0;
        for (int j = 0; j < 20; j++) begin
            ra[0] = 4'(j);
            ra[1] = 4'(j - 1);
            ra[2] = 4'd2;
            if (j == 2) begin
                regWrite      = 1'b1;
                writeRegister = 4'd2;
                writeData     = 32'hDEAD_BEEF;
            end else begin
                regWrite = 1'b0;
            end
            cycle("sweep");
        end

        // Random mixed traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle("random");
        end
        set_idle();
        for (int i = 0; i < 20; i++) cycle("drain");

        // Reset asserted in the middle of a sweep.
        for (int i = 0; i < 16; i++) write_reg(4'(i), 32'h0101_0101 * (i + 1), "refill");
        clearReq = 1'b1;
        cycle("clr_req2");
        clearReq = 1'b0;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) ra[k] = 4'($urandom_range(0, 15));
            cycle("sweep2");
        end
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < 2; j++) begin
            rand_inputs();
            cycle("mid_reset");
        end
        reset = 1'b1;
        set_idle();
        for (int a = 0; a < 20; a++) begin
            for (int k = 0; k < 3; k++) ra[k] = 4'(a + k);
            cycle("after_abort");
        end
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            cycle("random2");
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
